fsm_door_ctrl_gen2: RTL
=======================

Name: fsm_door_ctrl_gen2

Overview:
Second-generation garage/door motor controller. It drives a reversible motor (ml = close, mr = open) from two push keys and two end-position sensors.
- Adds key debouncing, an obstacle input with auto-reverse, and a timed dead-time before any direction reversal.
- Adds a travel-timeout fault, an optional auto-close timer and a blinking warning light.
- All timings are parameterised in clk2m cycles. Sits between the synchronised board I/O and the motor driver / signal lamps.

Parameters:
DEBOUNCE_CYC, 16, consecutive stable cycles required before a key level change is accepted (>=1)
DEADTIME_CYC, 2000, motor-off cycles in STOP before reversing (>=1)
TRAVEL_TIMEOUT_CYC, 2000000, max cycles in OPENING/CLOSING before FAULT (>=2)
AUTOCLOSE_CYC, 0, cycles in OPENED before automatic close; 0 disables auto-close
BLINK_HALF_CYC, 500000, half-period of the blinking lamp (>=1)

Ports:
rst_n  in  1  asynchronous active-low reset
clk2m  in  1  2 MHz system clock
key_up  in  1  open request key, asynchronous, bouncing
key_down  in  1  close request key, asynchronous, bouncing
sense_up  in  1  door fully open end switch, asynchronous
sense_down  in  1  door fully closed end switch, asynchronous
obstacle  in  1  light-barrier interrupted, asynchronous, active-high
ml  out  1  motor close direction
mr  out  1  motor open direction
light_red  out  1  red lamp
light_green  out  1  green lamp
fault  out  1  controller in FAULT state
state_o  out  3  current state encoding: IDLE=0, OPENING=1, CLOSING=2, OPENED=3, CLOSED=4, STOP=5, FAULT=6

Behaviour:
- Reset is asserted asynchronously with rst_n, clk2m.
- Reset values: state=IDLE, all timers 0, debounced key levels 0, sync flops 0, blink phase 0; ml=mr=0, light_red=1, light_green=0, fault=0, state_o=0.
- Input synchronisation: every input passes through 2 flip-flops. Sensors and obstacle are used synchronised only, not debounced.
- Key debounce: a per-key counter counts while the synced level differs from the debounced level and clears otherwise. When it reaches DEBOUNCE_CYC, the debounced level toggles.
- Press event: a one-cycle pulse on a debounced rising edge.
- Latency: a clean key edge at the input produces the resulting state (and motor output) change exactly DEBOUNCE_CYC+3 clk2m edges later.
- Outputs are a Moore decode of the registered state. ml and mr are never both 1, in any state.
- State transitions, evaluated in priority order within each state:
  - Any state except FAULT: synced sense_up & sense_down both 1 -> FAULT.
  - IDLE: sense_down -> CLOSED; else sense_up -> OPENED.
  - CLOSED: up_evt -> OPENING.
  - OPENED:
    - down_evt -> CLOSING.
    - Auto-close: if AUTOCLOSE_CYC>0, the timer counts while in OPENED and restarts on any key event or while obstacle=1. Timer = AUTOCLOSE_CYC-1 with obstacle=0 -> CLOSING.
  - OPENING (mr=1): sense_up -> OPENED; else timer = TRAVEL_TIMEOUT_CYC-1 -> FAULT; else down_evt -> STOP (reverse target CLOSING).
  - CLOSING (ml=1): sense_down -> CLOSED; else timer timeout -> FAULT; else obstacle or up_evt -> STOP (reverse target OPENING).
  - STOP:
    - Motors off; the target direction is stored in a 1-bit register when STOP is entered.
    - After DEADTIME_CYC cycles in STOP, go to the target direction.
    - If the target is CLOSING and obstacle=1 at expiry, go to OPENING instead.
    - Key events in STOP are ignored.
  - FAULT: motors off, fault=1; left only by reset.
  - Illegal encodings -> IDLE next cycle.
- Timers: one shared timer, cleared on every state change, saturating, width $clog2 of the largest parameter +1.
- Lamps:
  - OPENED: green=1, red=0.
  - CLOSED and IDLE: red=1, green=0.
  - OPENING, CLOSING and STOP: red=blink, green=0.
  - FAULT: red=blink, green=blink (in phase).
  - Blink phase toggles every BLINK_HALF_CYC cycles and is cleared on each state change, so the lamp starts off.
- Simultaneous key events: up_evt and down_evt in the same cycle are both ignored in CLOSED and OPENED. In a moving state, the event requesting the opposite direction wins.

Test Plan:
Params DEBOUNCE_CYC=4, DEADTIME_CYC=8, TRAVEL_TIMEOUT_CYC=100, AUTOCLOSE_CYC=50, BLINK_HALF_CYC=5.
- Reset with sense_down=1, release -> state_o 0 then 4 within 3 cycles; red=1, ml=mr=0.
- CLOSED, key_up bounces 1/0 every 2 cycles, then held -> no state change during bouncing; mr=1 exactly 7 cycles after the last edge; red toggles every 5 cycles.
- OPENING, press key_down -> STOP with ml=mr=0 for 8 cycles, then CLOSING (ml=1). obstacle=1 during CLOSING -> STOP, 8 cycles off, then OPENING.
- OPENED, no activity -> CLOSING after 50 cycles. Repeat with obstacle=1 for cycles 40-60 -> CLOSING only 50 cycles after obstacle falls (synced).
- OPENING with no sense_up for 100 cycles -> FAULT; fault=1, red and green blink together; key presses ignored; only rst_n recovers.
- Force sense_up=sense_down=1 in CLOSED -> FAULT within 3 cycles. Assert rst_n mid-CLOSING -> ml drops asynchronously, state_o=0.

Source files
------------

// File: rtl/fsm_door_ctrl_gen2_if.sv
`default_nettype none
// ==========================================================================
// fsm_door_ctrl_gen2_if : board-side keys/sensors and motor/lamp outputs
// Revision 1.0
// ==========================================================================
interface fsm_door_ctrl_gen2_if;
  logic       key_up;
  logic       key_down;
  logic       sense_up;
  logic       sense_down;
  logic       obstacle;
  logic       ml;
  logic       mr;
  logic       light_red;
  logic       light_green;
  logic       fault;
  logic [2:0] state_o;

  modport master (
    output key_up, key_down, sense_up, sense_down, obstacle,
    input  ml, mr, light_red, light_green, fault, state_o
  );

  modport slave (
    input  key_up, key_down, sense_up, sense_down, obstacle,
    output ml, mr, light_red, light_green, fault, state_o
  );
endinterface
`default_nettype wire

// File: rtl/fsm_door_ctrl_gen2.sv
`default_nettype none
// ==========================================================================
// fsm_door_ctrl_gen2 : door motor controller with debounce, dead-time,
// travel timeout, auto-close and blinking lamps.  Revision 1.0
// ==========================================================================
module fsm_door_ctrl_gen2 #(
  parameter int DEBOUNCE_CYC       = 16,
  parameter int DEADTIME_CYC       = 2000,
  parameter int TRAVEL_TIMEOUT_CYC = 2000000,
  parameter int AUTOCLOSE_CYC      = 0,
  parameter int BLINK_HALF_CYC     = 500000
) (
  input wire logic            rst_n,
  input wire logic            clk2m,
  fsm_door_ctrl_gen2_if.slave bus
);
  localparam int c_max_ab   = (DEBOUNCE_CYC > DEADTIME_CYC) ? DEBOUNCE_CYC : DEADTIME_CYC;
  localparam int c_max_cd   = (TRAVEL_TIMEOUT_CYC > AUTOCLOSE_CYC) ? TRAVEL_TIMEOUT_CYC : AUTOCLOSE_CYC;
  localparam int c_max_abcd = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_max      = (c_max_abcd > BLINK_HALF_CYC) ? c_max_abcd : BLINK_HALF_CYC;
  localparam int c_tw       = $clog2(c_max) + 1;
  localparam int c_dw       = $clog2(DEBOUNCE_CYC) + 1;
  localparam int c_bw       = $clog2(BLINK_HALF_CYC) + 1;

  localparam logic [c_tw-1:0] c_dead_last   = c_tw'(DEADTIME_CYC - 1);
  localparam logic [c_tw-1:0] c_travel_last = c_tw'(TRAVEL_TIMEOUT_CYC - 1);
  localparam logic [c_tw-1:0] c_auto_last   = c_tw'((AUTOCLOSE_CYC > 0) ? AUTOCLOSE_CYC - 1 : 0);
  localparam logic [c_dw-1:0] c_deb_last    = c_dw'(DEBOUNCE_CYC - 1);
  localparam logic [c_bw-1:0] c_blink_last  = c_bw'(BLINK_HALF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPENING = 3'd1,
    S_CLOSING = 3'd2,
    S_OPENED  = 3'd3,
    S_CLOSED  = 3'd4,
    S_STOP    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           sync1_q, sync2_q;
  logic [1:0]           deb_q, deb_d;
  logic [1:0]           evt_q, evt_d;
  logic [1:0][c_dw-1:0] cnt_q, cnt_d;
  logic [c_tw-1:0]      timer_q, timer_d;
  logic [c_bw-1:0]      blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic                 target_q, target_d;
  logic                 ml_q, ml_d, mr_q, mr_d;
  logic                 red_q, red_d, green_q, green_d;
  logic                 fault_q, fault_d;

  logic [4:0] raw_in;
  logic       up_evt, down_evt, s_up, s_down, obs;

  assign raw_in   = {bus.obstacle, bus.sense_down, bus.sense_up, bus.key_down, bus.key_up};
  assign up_evt   = evt_q[0];
  assign down_evt = evt_q[1];
  assign s_up     = sync2_q[2];
  assign s_down   = sync2_q[3];
  assign obs      = sync2_q[4];

  // Debounced level flips on the DEBOUNCE_CYC-th consecutive differing cycle.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == c_deb_last) begin
          deb_d[k] = ~deb_q[k];
          cnt_d[k] = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + c_dw'(1);
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
    evt_d = deb_d & ~deb_q;
  end

  // target_q: 1 = resume OPENING after dead-time, 0 = resume CLOSING
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (state_q != S_FAULT && s_up && s_down) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (s_down)    state_d = S_CLOSED;
          else if (s_up) state_d = S_OPENED;
        end
        S_CLOSED: if (up_evt && !down_evt) state_d = S_OPENING;
        S_OPENED: begin
          if (down_evt && !up_evt) begin
            state_d = S_CLOSING;
          end else if (AUTOCLOSE_CYC > 0 && timer_q == c_auto_last && !obs && !up_evt) begin
            state_d = S_CLOSING;
          end
        end
        S_OPENING: begin
          if (s_up) begin
            state_d = S_OPENED;
          end else if (timer_q == c_travel_last) begin
            state_d = S_FAULT;
          end else if (down_evt) begin
            state_d  = S_STOP;
            target_d = 1'b0;
          end
        end
        S_CLOSING: begin
          if (s_down) begin
            state_d = S_CLOSED;
          end else if (timer_q == c_travel_last) begin
            state_d = S_FAULT;
          end else if (obs || up_evt) begin
            state_d  = S_STOP;
            target_d = 1'b1;
          end
        end
        S_STOP: begin
          if (timer_q == c_dead_last) begin
            state_d = (target_q || obs) ? S_OPENING : S_CLOSING;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_OPENED && (up_evt || down_evt || obs)) begin
      timer_d = '0;
    end else if (timer_q == {c_tw{1'b1}}) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + c_tw'(1);
    end

    // Phase restarts on every state change so a blinking lamp starts dark.
    blink_cnt_d = blink_cnt_q + c_bw'(1);
    phase_d     = phase_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == c_blink_last) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    ml_d    = (state_d == S_CLOSING);
    mr_d    = (state_d == S_OPENING);
    fault_d = (state_d == S_FAULT);
    case (state_d)
      S_OPENED:                   begin red_d = 1'b0;    green_d = 1'b1;    end
      S_OPENING, S_CLOSING, S_STOP: begin red_d = phase_d; green_d = 1'b0;    end
      S_FAULT:                    begin red_d = phase_d; green_d = phase_d; end
      default:                    begin red_d = 1'b1;    green_d = 1'b0;    end
    endcase
  end

  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      evt_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      target_q    <= 1'b0;
      ml_q        <= 1'b0;
      mr_q        <= 1'b0;
      red_q       <= 1'b1;
      green_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= raw_in;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      evt_q       <= evt_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      target_q    <= target_d;
      ml_q        <= ml_d;
      mr_q        <= mr_d;
      red_q       <= red_d;
      green_q     <= green_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.ml          = ml_q;
  assign bus.mr          = mr_q;
  assign bus.light_red   = red_q;
  assign bus.light_green = green_q;
  assign bus.fault       = fault_q;
  assign bus.state_o     = state_q;
endmodule
`default_nettype wire
